// File: rtl/imem_boot_loader.sv
// Streams instruction words into IMEM from BASE_ADDR, holding the core in reset until the image is loaded and settled.
// Write latency 1 cycle after accept, 1 word/cycle; ld_ready_o drops at the last word, on overflow, and outside LOAD.
module imem_boot_loader #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        ld_valid_i,
    input  logic [31:0] ld_data_i,
    input  logic        ld_last_i,
    output logic        ld_ready_o,
    output logic        wr_en_imem_o,
    output logic [31:0] wr_addr_imem_o,
    output logic [31:0] wr_instr_imem_o,
    output logic        cpu_reset_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] word_cnt_o
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_ERROR} state_t;

    localparam logic [15:0] LP_DEPTH    = 16'(DEPTH_WORDS);
    localparam logic [15:0] LP_LAST_IDX = 16'(DEPTH_WORDS - 1);
    localparam logic [7:0]  LP_HOLD_END = 8'(HOLD_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic [7:0]  r_hold;
    logic        r_wr_en;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wr_instr;
    logic        w_ready;
    logic        w_accept;
    logic        w_restart;

    // Ready is decoded from registered state only, never from ld_valid_i.
    assign w_ready   = (r_state == S_LOAD) && (r_cnt < LP_DEPTH);
    assign w_accept  = ld_valid_i && w_ready;
    assign w_restart = start_i && ((r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_ERROR));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_next = S_LOAD;
            S_LOAD: begin
                if (w_accept) begin
                    if (ld_last_i)               w_next = S_HOLD;
                    else if (r_cnt == LP_LAST_IDX) w_next = S_ERROR;
                end
            end
            S_HOLD:  if (r_hold == LP_HOLD_END) w_next = S_RUN;
            S_RUN:   if (start_i) w_next = S_LOAD;
            S_ERROR: if (start_i) w_next = S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= 16'd0;
            r_hold     <= 8'd0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= BASE_ADDR;
            r_wr_instr <= 32'd0;
        end else begin
            r_wr_en <= w_accept;
            // Address uses the pre-increment count; 32-bit add wraps freely.
            if (w_accept) begin
                r_wr_addr  <= BASE_ADDR + {14'd0, r_cnt, 2'b00};
                r_wr_instr <= ld_data_i;
                r_cnt      <= r_cnt + 16'd1;
            end else if (w_restart) begin
                r_cnt <= 16'd0;
            end
            r_hold <= (r_state == S_HOLD) ? r_hold + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        ld_ready_o  = w_ready;
        cpu_reset_o = (r_state != S_RUN);
        busy_o      = (r_state == S_LOAD) || (r_state == S_HOLD);
        done_o      = (r_state == S_RUN);
        err_o       = (r_state == S_ERROR);
    end

    assign wr_en_imem_o    = r_wr_en;
    assign wr_addr_imem_o  = r_wr_addr;
    assign wr_instr_imem_o = r_wr_instr;
    assign word_cnt_o      = r_cnt;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: per-cycle vector tables plus a write scoreboard on two instances.
module tb_imem_boot_loader;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic        ld_valid_i;
    logic [31:0] ld_data_i;
    logic        ld_last_i;
    logic        sel_b;

    logic        a_start, a_valid, b_start, b_valid;
    logic        a_rdy, a_wen, a_crst, a_busy, a_done, a_err;
    logic        b_rdy, b_wen, b_crst, b_busy, b_done, b_err;
    logic [31:0] a_waddr, a_wdat, b_waddr, b_wdat;
    logic [15:0] a_cnt, b_cnt;

    assign a_start = start_i & ~sel_b;
    assign a_valid = ld_valid_i & ~sel_b;
    assign b_start = start_i & sel_b;
    assign b_valid = ld_valid_i & sel_b;

    imem_boot_loader #(.DEPTH_WORDS(4), .BASE_ADDR(32'h0000_0000), .HOLD_CYCLES(4)) u_dut_a (
        .clk(clk), .reset(reset), .start_i(a_start), .ld_valid_i(a_valid),
        .ld_data_i(ld_data_i), .ld_last_i(ld_last_i), .ld_ready_o(a_rdy),
        .wr_en_imem_o(a_wen), .wr_addr_imem_o(a_waddr), .wr_instr_imem_o(a_wdat),
        .cpu_reset_o(a_crst), .busy_o(a_busy), .done_o(a_done), .err_o(a_err),
        .word_cnt_o(a_cnt)
    );

    imem_boot_loader #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0400), .HOLD_CYCLES(4)) u_dut_b (
        .clk(clk), .reset(reset), .start_i(b_start), .ld_valid_i(b_valid),
        .ld_data_i(ld_data_i), .ld_last_i(ld_last_i), .ld_ready_o(b_rdy),
        .wr_en_imem_o(b_wen), .wr_addr_imem_o(b_waddr), .wr_instr_imem_o(b_wdat),
        .cpu_reset_o(b_crst), .busy_o(b_busy), .done_o(b_done), .err_o(b_err),
        .word_cnt_o(b_cnt)
    );

    typedef struct {
        logic        st;
        logic        vl;
        logic [31:0] dat;
        logic        lst;
        logic        rdy;
        logic [15:0] cnt;
        logic        crst;
        logic        busy;
        logic        done;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    vec_t tbl[$];
    wr_t  qa[$];
    wr_t  qb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int st, input int vl, input logic [31:0] dat, input int lst,
                                input int rdy, input int cnt, input int crst, input int busy,
                                input int done, input int err);
        vec_t v;
        v.st   = 1'(st);
        v.vl   = 1'(vl);
        v.dat  = dat;
        v.lst  = 1'(lst);
        v.rdy  = 1'(rdy);
        v.cnt  = 16'(cnt);
        v.crst = 1'(crst);
        v.busy = 1'(busy);
        v.done = 1'(done);
        v.err  = 1'(err);
        return v;
    endfunction

    task automatic mon_pop(input logic b, input logic [31:0] ad, input logic [31:0] d);
        wr_t e;
        if ((b ? qb.size() : qa.size()) == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL spurious_write_%s got=addr %h data %h exp=no write", b ? "b" : "a", ad, d);
        end else begin
            e = b ? qb.pop_front() : qa.pop_front();
            chk(b ? "wr_addr_b" : "wr_addr_a", ad, e.a);
            chk(b ? "wr_data_b" : "wr_data_a", d, e.d);
        end
    endtask

    always @(negedge clk) begin
        if (a_wen === 1'b1) mon_pop(1'b0, a_waddr, a_wdat);
        if (b_wen === 1'b1) mon_pop(1'b1, b_waddr, b_wdat);
    end

    task automatic run_table(input logic b, input logic [31:0] base, input string nm);
        logic        rdy, crst, busy, done, err;
        logic [15:0] cnt;
        wr_t         e;
        for (int i = 0; i < tbl.size(); i++) begin
            start_i    = tbl[i].st;
            ld_valid_i = tbl[i].vl;
            ld_data_i  = tbl[i].dat;
            ld_last_i  = tbl[i].lst;
            @(negedge clk);
            rdy  = b ? b_rdy  : a_rdy;
            crst = b ? b_crst : a_crst;
            busy = b ? b_busy : a_busy;
            done = b ? b_done : a_done;
            err  = b ? b_err  : a_err;
            cnt  = b ? b_cnt  : a_cnt;
            chk($sformatf("%s[%0d].ready", nm, i), 32'(rdy), 32'(tbl[i].rdy));
            chk($sformatf("%s[%0d].word_cnt", nm, i), 32'(cnt), 32'(tbl[i].cnt));
            chk($sformatf("%s[%0d].cpu_reset", nm, i), 32'(crst), 32'(tbl[i].crst));
            chk($sformatf("%s[%0d].busy", nm, i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("%s[%0d].done", nm, i), 32'(done), 32'(tbl[i].done));
            chk($sformatf("%s[%0d].err", nm, i), 32'(err), 32'(tbl[i].err));
            if (tbl[i].vl && tbl[i].rdy) begin
                e.a = base + {14'd0, tbl[i].cnt, 2'b00};
                e.d = tbl[i].dat;
                if (b) qb.push_back(e);
                else   qa.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        start_i    = 1'b0;
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
        ld_data_i  = 32'd0;
        tbl.delete();
    endtask

    task automatic chk_rst(input logic b, input logic [31:0] base, input string nm);
        chk({nm, ".ready"},     32'(b ? b_rdy  : a_rdy),  32'd0);
        chk({nm, ".wr_en"},     32'(b ? b_wen  : a_wen),  32'd0);
        chk({nm, ".wr_addr"},   b ? b_waddr : a_waddr,    base);
        chk({nm, ".wr_instr"},  b ? b_wdat  : a_wdat,     32'd0);
        chk({nm, ".cpu_reset"}, 32'(b ? b_crst : a_crst), 32'd1);
        chk({nm, ".busy"},      32'(b ? b_busy : a_busy), 32'd0);
        chk({nm, ".done"},      32'(b ? b_done : a_done), 32'd0);
        chk({nm, ".err"},       32'(b ? b_err  : a_err),  32'd0);
        chk({nm, ".word_cnt"},  32'(b ? b_cnt  : a_cnt),  32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start_i    = 1'b0;
        ld_valid_i = 1'b0;
        ld_data_i  = 32'd0;
        ld_last_i  = 1'b0;
        sel_b      = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk_rst(1'b0, 32'h0000_0000, "por_a");
        chk_rst(1'b1, 32'h0000_0400, "por_b");
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic 3-word image; release lands 4 cycles after the final write.
        tbl.push_back(mk(1, 0, 32'h0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h2008_0005, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 32'h2009_0007, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 32'h0109_5020, 1, 1, 2, 1, 1, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 32'h0, 0, 0, 3, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 0, 0, 3, 0, 0, 1, 0));
        run_table(1'b0, 32'h0000_0000, "basic");

        // Reload into overflow, recover from ERROR, reload with ignored starts.
        tbl.push_back(mk(1, 0, 32'h0, 0, 0, 3, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 32'hA000_0000 + 32'(i), 0, 1, i, 1, 1, 0, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 1, 32'hA000_0004, 0, 0, 4, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 32'h0, 0, 0, 4, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 32'hB000_0000, 1, 1, 0, 1, 1, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 32'h0, 0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 32'h0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 32'hC000_0000, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 32'hC000_0001, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 32'hC000_0002, 1, 1, 2, 1, 1, 0, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 0, 32'h0, 0, 0, 3, 1, 1, 0, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 0, 32'h0, 0, 0, 3, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 0, 0, 3, 0, 0, 1, 0));
        run_table(1'b0, 32'h0000_0000, "ovf_reload");

        // Two words into a reload, then asynchronous reset between edges.
        tbl.push_back(mk(1, 0, 32'h0, 0, 0, 3, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 32'hD000_0000, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 32'hD000_0001, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 0, 1, 2, 1, 1, 0, 0));
        run_table(1'b0, 32'h0000_0000, "pre_rst");
        #2 reset = 1'b0;
        #1;
        chk_rst(1'b0, 32'h0000_0000, "async_a");
        chk_rst(1'b1, 32'h0000_0400, "async_b");
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        tbl.push_back(mk(0, 1, 32'hDEAD_0000, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'hDEAD_0000, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'hDEAD_0000, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'hE000_0000, 1, 1, 0, 1, 1, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 32'h0, 0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 0, 0, 1, 0, 0, 1, 0));
        run_table(1'b0, 32'h0000_0000, "post_rst");

        // Stalled source on the 0x400-based instance.
        sel_b = 1'b1;
        tbl.push_back(mk(1, 0, 32'h0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'hF000_0000, 0, 1, 0, 1, 1, 0, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 0, 32'h0, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 32'hF000_0001, 1, 1, 1, 1, 1, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 32'h0, 0, 0, 2, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 0, 0, 2, 0, 0, 1, 0));
        run_table(1'b1, 32'h0000_0400, "stall");
        sel_b = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("pending_writes_a", 32'(qa.size()), 32'd0);
        chk("pending_writes_b", 32'(qb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sequences instruction-memory initialisation for the single-cycle MIPS core.
- Accepts a stream of 32-bit instruction words over a valid/ready port and writes them into the instruction memory through its write port (write enable, write data, word address), starting at a base address.
- Holds the CPU in reset during loading, then releases it after a programmable settle delay.
- Sits between a host/debug streaming source and the core top level.

Parameters:
- DEPTH_WORDS, 256, maximum number of words loadable; range 1..65535.
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word; must be word-aligned.
- HOLD_CYCLES, 4, cycles the CPU reset stays asserted after the final write; range 1..255.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start_i  input  1  single-cycle pulse; begins a new load.
- ld_valid_i  input  1  source has a word on ld_data_i.
- ld_data_i  input  32  instruction word.
- ld_last_i  input  1  qualifies ld_data_i as final word of the image.
- ld_ready_o  output  1  loader accepts a word this cycle.
- wr_en_imem_o  output  1  instruction-memory write enable.
- wr_addr_imem_o  output  32  byte address of the write.
- wr_instr_imem_o  output  32  instruction word to write.
- cpu_reset_o  output  1  active-high reset to the core; 1 = held.
- busy_o  output  1  high in LOAD or HOLD.
- done_o  output  1  high in RUN.
- err_o  output  1  high in ERROR.
- word_cnt_o  output  16  words accepted in the current load.

Behaviour:
- States: IDLE, LOAD, HOLD, RUN, ERROR.
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, cpu_reset_o=1, ld_ready_o=0, wr_en_imem_o=0.
  - wr_addr_imem_o=BASE_ADDR, wr_instr_imem_o=0, word_cnt_o=0.
  - busy_o=0, done_o=0, err_o=0, hold counter=0.
- Reset asserted mid-load aborts immediately. Any write in flight is dropped; memory contents are undefined.
- IDLE:
  - start_i=1 moves to LOAD next cycle and clears word_cnt_o to 0.
  - Otherwise IDLE holds. CPU stays in reset.
- LOAD:
  - ld_ready_o=1 while word_cnt_o < DEPTH_WORDS.
  - Accept happens on a cycle with ld_valid_i & ld_ready_o.
  - On accept, the next cycle presents exactly one write pulse:
    - wr_en_imem_o=1 for one cycle.
    - wr_addr_imem_o = BASE_ADDR + 4*word_cnt_o, using the pre-increment count.
    - wr_instr_imem_o = the accepted word.
    - word_cnt_o increments by 1 in that same cycle.
  - Write latency is 1 cycle. Back-to-back accepts give back-to-back writes; throughput is 1 word/cycle.
  - Address arithmetic is 32-bit and wraps modulo 2^32 without error.
- Transitions out of LOAD:
  - Accept with ld_last_i=1: ld_ready_o drops next cycle and state goes to HOLD. The last write pulse coincides with the first HOLD cycle.
  - Accept of word number DEPTH_WORDS with ld_last_i=0: ld_ready_o drops next cycle and state goes to ERROR. That word is still written.
- start_i in LOAD or HOLD is ignored.
- HOLD:
  - cpu_reset_o stays 1.
  - The hold counter counts HOLD_CYCLES cycles, then state goes to RUN.
- RUN:
  - cpu_reset_o=0, done_o=1.
  - Entry into RUN is the first cycle cpu_reset_o is 0.
  - start_i=1: cpu_reset_o=1 and state=LOAD on the next edge; count cleared. This is a reload.
- ERROR:
  - err_o=1, cpu_reset_o=1, ld_ready_o=0.
  - Left only via start_i, which restarts LOAD with the count cleared, or via reset.
- Outputs are registered; there is no combinational path from inputs to outputs.
- ld_ready_o must not depend on ld_valid_i.
- wr_en_imem_o is never high outside the cycle following an accept.

Test Plan:
- Reset then start_i; stream 3 words 0x20080005, 0x20090007, 0x01095020 (last on the third), ld_valid_i held high -> writes at 0x0, 0x4, 0x8 on consecutive cycles; word_cnt_o=3; cpu_reset_o falls exactly 4 cycles after the last write cycle; done_o=1.
- Stalled source: ld_valid_i toggling 1,0,0,1 with BASE_ADDR=0x400 -> exactly 2 writes at 0x400 and 0x404; no write pulse in idle gaps.
- Overflow: DEPTH_WORDS=4, 4 words sent, none with last -> 4 writes (0x0..0xC), then err_o=1, ld_ready_o=0, cpu_reset_o=1; a 5th ld_valid_i is never accepted.
- Recovery and reload: from ERROR, pulse start_i and load 1 word with last -> RUN reached. Pulse start_i in RUN -> cpu_reset_o=1 next cycle, word_cnt_o=0, new image written from BASE_ADDR.
- Async reset mid-stream: drop reset between clock edges during LOAD after 2 words -> outputs return to reset values immediately, without a clock edge. After release, start_i is required before any ld_ready_o.
- start_i pulsed during LOAD and during HOLD -> no effect; word_cnt_o and the write address sequence are unchanged.
